// File: rtl/field_pkg.sv
// Shared field-arithmetic definitions for the SM2 / NIST P-256 datapath.
// Holds the field width, the two curve primes and the multiplier FSM state encoding.
package field_pkg;

    localparam int FIELD_W = 256;

    localparam logic [FIELD_W-1:0] SM2_P =
        256'hfffffffeffffffffffffffffffffffffffffffff00000000ffffffffffffffff;

    localparam logic [FIELD_W-1:0] NIST_P =
        256'hffffffff00000001000000000000000000000000ffffffffffffffffffffffff;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/mod_add.sv
// Combinational modular adder: res = (a + b) mod p, for a, b < p.
// Ports: a, b, p (WIDTH) in; res (WIDTH) out.
module mod_add #(
    parameter int WIDTH = 256
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] res
);

    logic [WIDTH+1:0] sum;
    logic [WIDTH+1:0] diff;
    logic [WIDTH+1:0] sel;
    logic             unused_hi;

    // Two guard bits: sum < 2^(WIDTH+1), so bit WIDTH+1 of diff is a clean borrow.
    assign sum  = {2'b00, a} + {2'b00, b};
    assign diff = sum - {2'b00, p};
    assign sel  = diff[WIDTH+1] ? sum : diff;
    assign res  = sel[WIDTH-1:0];

    // With valid operands the selected value is already < p < 2^WIDTH.
    assign unused_hi = ^sel[WIDTH+1:WIDTH];

endmodule

// File: rtl/mod_mul_step.sv
// One double-and-add iteration: acc_next = 2*acc (+ a_r if b_bit) mod p_r.
// Ports: acc, a_r, p_r (WIDTH), b_bit in; acc_next (WIDTH) out.
module mod_mul_step
    import field_pkg::*;
#(
    parameter int WIDTH = FIELD_W
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] a_r,
    input  logic [WIDTH-1:0] p_r,
    input  logic             b_bit,
    output logic [WIDTH-1:0] acc_next
);

    logic [WIDTH-1:0] dbl;
    logic [WIDTH-1:0] dbl_add;

    mod_add #(.WIDTH(WIDTH)) u_double (
        .a   (acc),
        .b   (acc),
        .p   (p_r),
        .res (dbl)
    );

    mod_add #(.WIDTH(WIDTH)) u_add (
        .a   (dbl),
        .b   (a_r),
        .p   (p_r),
        .res (dbl_add)
    );

    assign acc_next = b_bit ? dbl_add : dbl;

endmodule

// File: rtl/mod_mul_serial.sv
// Bit-serial MSB-first modular multiplier: mod_mul_res = (a*b) mod p.
// Ports: clk, rst_n, start, a, b, p in; busy, done, mod_mul_res out.
module mod_mul_serial
    import field_pkg::*;
#(
    parameter int WIDTH = FIELD_W,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] p,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] mod_mul_res
);

    mul_state_t       state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] p_r;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc_next;

    mod_mul_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .a_r      (a_r),
        .p_r      (p_r),
        .b_bit    (b_r[cnt]),
        .acc_next (acc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            mod_mul_res <= '0;
            a_r         <= '0;
            b_r         <= '0;
            p_r         <= '0;
            acc         <= '0;
            cnt         <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        p_r   <= p;
                        acc   <= '0;
                        cnt   <= CNT_W'(WIDTH - 1);
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    if (cnt == '0) begin
                        mod_mul_res <= acc_next;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
